// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU / SD-DMA data-memory arbiter.
// Imported by the arbiter top and its pick sub-module.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int DEFAULT_TIMEOUT     = 1024;
  localparam int DEFAULT_MAX_CPU_RUN = 4;

  localparam int TMO_W = 11;
  localparam int RUN_W = 4;

  // Saturating increment for the CPU run counter.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
    logic [RUN_W-1:0] nxt;
    nxt = (run == {RUN_W{1'b1}}) ? run : run + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational pick: CPU priority, except DMA wins once the CPU has
// taken MAX_CPU_RUN consecutive grants while DMA was waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_CPU_RUN = DEFAULT_MAX_CPU_RUN
) (
  input  logic             cpu_valid,
  input  logic             dma_valid,
  input  logic [RUN_W-1:0] cpu_run,
  output logic             grant_valid,
  output logic             owner
);

  logic dma_turn;

  assign dma_turn = (cpu_run == RUN_W'(MAX_CPU_RUN));

  always_comb begin
    grant_valid = cpu_valid | dma_valid;
    owner       = OWN_CPU;
    if (dma_valid && (!cpu_valid || dma_turn)) begin
      owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/sd_dma_mem_arbiter.sv
// Serializes CPU load/store and SD DMA requests onto one data-memory port,
// with CPU priority, bounded DMA starvation and a per-access ack timeout.
module sd_dma_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = DEFAULT_MAX_CPU_RUN,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  // CPU load/store path
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  // SD DMA engine
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_read,
  input  logic              dma_write,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  // Memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              grant_dma,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: each requester holds read/write, addr and wdata as levels
  // until it sees its one-cycle ready pulse; the request is served exactly
  // once because arbitration only happens in IDLE, after the RESP cycle.

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [RUN_W-1:0]  cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dma_ready_q, dma_ready_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_err_q, dma_err_d;

  logic              cpu_valid, dma_valid;
  logic              grant_valid, pick_owner;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              resp_fire;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  assign cpu_valid = cpu_read | cpu_write;
  assign dma_valid = dma_read | dma_write;

  mem_arb_pick #(
    .MAX_CPU_RUN (MAX_CPU_RUN)
  ) u_pick (
    .cpu_valid   (cpu_valid),
    .dma_valid   (dma_valid),
    .cpu_run     (cpu_run_q),
    .grant_valid (grant_valid),
    .owner       (pick_owner)
  );

  // Write wins when a requester raises both read and write.
  assign sel_write = (pick_owner == OWN_DMA) ? dma_write : cpu_write;
  assign sel_addr  = (pick_owner == OWN_DMA) ? dma_addr  : cpu_addr;
  assign sel_wdata = (pick_owner == OWN_DMA) ? dma_wdata : cpu_wdata;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    tmo_cnt_d   = tmo_cnt_q;
    cpu_run_d   = cpu_run_q;
    busy_d      = busy_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    dma_ready_d = 1'b0;
    dma_rdata_d = dma_rdata_q;
    dma_err_d   = dma_err_q;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      IDLE: begin
        // The run counter only measures CPU grants taken while DMA waits.
        if (!dma_valid) begin
          cpu_run_d = '0;
        end else if (grant_valid && (pick_owner == OWN_DMA)) begin
          cpu_run_d = '0;
        end else if (grant_valid) begin
          cpu_run_d = run_inc(cpu_run_q);
        end

        if (grant_valid) begin
          owner_d     = pick_owner;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_write;
          mem_re_d    = !sel_write;
          tmo_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_ack) begin
          resp_fire = 1'b1;
          resp_data = mem_rdata;
          resp_err  = 1'b0;
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_fire = 1'b1;
          resp_data = '0;
          resp_err  = 1'b1;
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d   = 1'b0;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // Completion is routed only to the latched owner.
    if (resp_fire) begin
      if (owner_q == OWN_DMA) begin
        dma_ready_d = 1'b1;
        dma_rdata_d = resp_data;
        dma_err_d   = resp_err;
      end else begin
        cpu_ready_d = 1'b1;
        cpu_rdata_d = resp_data;
        cpu_err_d   = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      cpu_run_q   <= '0;
      busy_q      <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
      dma_ready_q <= 1'b0;
      dma_rdata_q <= '0;
      dma_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
      dma_ready_q <= dma_ready_d;
      dma_rdata_q <= dma_rdata_d;
      dma_err_q   <= dma_err_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign dma_ready = dma_ready_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_err   = dma_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign grant_dma = owner_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sd_dma_mem_arbiter.sv
// Bench for sd_dma_mem_arbiter: requester drivers, a memory responder that
// checks each access, and a ready monitor that pops expected responses.
module tb_sd_dma_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAX_RUN = 4;
  localparam int TMO     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata;
  logic          cpu_read, cpu_write, dma_read, dma_write;
  logic          cpu_ready, cpu_err, dma_ready, dma_err;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_rdata;
  logic          mem_re, mem_we, mem_ack;
  logic          grant_dma, busy;
  logic [1:0]    state_dbg;

  sd_dma_mem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MAX_CPU_RUN (MAX_RUN), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_read (cpu_read),
    .cpu_write (cpu_write), .cpu_ready (cpu_ready), .cpu_rdata (cpu_rdata),
    .cpu_err (cpu_err),
    .dma_addr (dma_addr), .dma_wdata (dma_wdata), .dma_read (dma_read),
    .dma_write (dma_write), .dma_ready (dma_ready), .dma_rdata (dma_rdata),
    .dma_err (dma_err),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_re (mem_re),
    .mem_we (mem_we), .mem_ack (mem_ack), .mem_rdata (mem_rdata),
    .grant_dma (grant_dma), .busy (busy), .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] len;   // expected strobe cycles, 0 = not checked
  } acc_t;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] lat;   // cycles from strobe rise to ready
  } rsp_t;

  acc_t exp_cpu_mem_q[$];
  acc_t exp_dma_mem_q[$];
  rsp_t exp_cpu_rsp_q[$];
  rsp_t exp_dma_rsp_q[$];
  logic exp_grant_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEBABE;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] mem_store [logic [31:0]];
  int   ack_lat     = 0;   // -1 = never ack
  logic late_ack    = 1'b0;
  logic chk_gap     = 1'b0;
  logic gap_first   = 1'b0;
  int   last_rise   = 0;
  int   n_dma_acc   = 0;

  initial begin
    logic strobe_prev;
    logic owner;
    int   scnt;
    acc_t cur;
    strobe_prev = 1'b0;
    scnt        = 0;
    cur         = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_re || mem_we) begin
        if (!strobe_prev) begin
          scnt = 0;
          if (chk_gap && !gap_first) check("grant_gap", cyc - last_rise, 3);
          gap_first = 1'b0;
          last_rise = cyc;
          owner = (mem_addr >= 32'h1000);
          if (owner) n_dma_acc++;
          check("grant_dma", grant_dma, owner);
          check("busy_issue", busy, 1'b1);
          if (exp_grant_q.size() > 0) check("grant_order", owner, exp_grant_q.pop_front());
          if (owner) begin
            check("dma_mem_expected", exp_dma_mem_q.size() > 0, 1'b1);
            cur = (exp_dma_mem_q.size() > 0) ? exp_dma_mem_q.pop_front() : '0;
          end else begin
            check("cpu_mem_expected", exp_cpu_mem_q.size() > 0, 1'b1);
            cur = (exp_cpu_mem_q.size() > 0) ? exp_cpu_mem_q.pop_front() : '0;
          end
          check("mem_strobes", {mem_re, mem_we}, {~cur.we, cur.we});
          check("mem_addr", mem_addr, cur.addr);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end else begin
          scnt++;
        end
        if (ack_lat >= 0 && scnt == ack_lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_val(mem_addr);
        end
      end else if (strobe_prev && cur.len != 0) begin
        check("strobe_len", scnt + 1, cur.len);
      end
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        late_ack  = 1'b0;
      end
      strobe_prev = mem_re || mem_we;
    end
  end

  // ---------------- ready monitor ----------------
  initial begin
    logic cpu_prev, dma_prev;
    rsp_t r;
    cpu_prev = 1'b0;
    dma_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        check("cpu_ready_pulse", cpu_prev, 1'b0);
        check("ready_exclusive", dma_ready, 1'b0);
        check("cpu_busy_resp", busy, 1'b1);
        check("cpu_ready_expected", exp_cpu_rsp_q.size() > 0, 1'b1);
        if (exp_cpu_rsp_q.size() > 0) begin
          r = exp_cpu_rsp_q.pop_front();
          if (r.chk_data) check("cpu_rdata", cpu_rdata, r.rdata);
          check("cpu_err", cpu_err, r.err);
          check("cpu_latency", cyc - last_rise, r.lat);
        end
      end
      if (dma_ready) begin
        check("dma_ready_pulse", dma_prev, 1'b0);
        check("dma_busy_resp", busy, 1'b1);
        check("dma_ready_expected", exp_dma_rsp_q.size() > 0, 1'b1);
        if (exp_dma_rsp_q.size() > 0) begin
          r = exp_dma_rsp_q.pop_front();
          if (r.chk_data) check("dma_rdata", dma_rdata, r.rdata);
          check("dma_err", dma_err, r.err);
          check("dma_latency", cyc - last_rise, r.lat);
        end
      end
      cpu_prev = cpu_ready;
      dma_prev = dma_ready;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic acc_t mk_acc(input logic w, input logic [31:0] a, input logic [31:0] d);
    acc_t m;
    m.we    = w;
    m.addr  = a;
    m.wdata = d;
    m.len   = (ack_lat < 0) ? 16'(TMO) : 16'(ack_lat + 1);
    return m;
  endfunction

  function automatic rsp_t mk_rsp(input logic w, input logic [31:0] a);
    rsp_t e;
    e.chk_data = !w || (ack_lat < 0);
    e.rdata    = (ack_lat < 0) ? 32'h0 : init_val(a);
    e.err      = (ack_lat < 0);
    e.lat      = (ack_lat < 0) ? 16'(TMO) : 16'(ack_lat + 1);
    return e;
  endfunction

  task automatic wait_cpu_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ready) return;
    end
    check("cpu_ready_timeout", cpu_ready, 1'b1);
  endtask

  task automatic wait_dma_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dma_ready) return;
    end
    check("dma_ready_timeout", dma_ready, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge that shows the ready pulse.
  task automatic cpu_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_cpu_mem_q.push_back(mk_acc(w, a, d));
    exp_cpu_rsp_q.push_back(mk_rsp(w, a));
    cpu_read  = r;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
    wait_cpu_ready();
  endtask

  task automatic dma_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_dma_mem_q.push_back(mk_acc(w, a, d));
    exp_dma_rsp_q.push_back(mk_rsp(w, a));
    dma_read  = r;
    dma_write = w;
    dma_addr  = a;
    dma_wdata = d;
    wait_dma_ready();
  endtask

  task automatic cpu_idle();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic dma_idle();
    dma_read  = 1'b0;
    dma_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, cpu_ready, 1'b0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_cpu_err"},   cpu_err, 1'b0);
    check({tag, "_dma_ready"}, dma_ready, 1'b0);
    check({tag, "_dma_rdata"}, dma_rdata, 32'h0);
    check({tag, "_dma_err"},   dma_err, 1'b0);
    check({tag, "_mem_addr"},  mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_strb"},  {mem_re, mem_we}, 2'b00);
    check({tag, "_grant_dma"}, grant_dma, 1'b0);
    check({tag, "_busy"},      busy, 1'b0);
    check({tag, "_state"},     state_dbg, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    dma_addr = '0; dma_wdata = '0; dma_read = 1'b0; dma_write = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // CPU read, memory acks one cycle after the strobe rises
    ack_lat = 1;
    cpu_access(1'b1, 1'b0, 32'h100, 32'h0);
    cpu_idle();
    repeat (4) @(negedge clk);

    // DMA write burst, address advancing after each ready pulse
    ack_lat = 0;
    base = n_dma_acc;
    for (int i = 0; i < 3; i++) dma_access(1'b0, 1'b1, 32'h2000 + 32'(4 * i), 32'h12345678);
    dma_idle();
    repeat (6) @(negedge clk);
    check("dma_write_count", n_dma_acc - base, 3);
    check("dma_store_2000", mem_store.exists(32'h2000) ? mem_store[32'h2000] : 32'h0, 32'h12345678);
    check("dma_store_2008", mem_store.exists(32'h2008) ? mem_store[32'h2008] : 32'h0, 32'h12345678);

    // Both sides held continuously: C,C,C,C,D repeating, every 3 cycles
    ack_lat = 0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < MAX_RUN; j++) exp_grant_q.push_back(1'b0);
      exp_grant_q.push_back(1'b1);
    end
    chk_gap   = 1'b1;
    gap_first = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) cpu_access(1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h0);
        cpu_idle();
      end
      begin
        for (int i = 0; i < 2; i++) dma_access(1'b1, 1'b0, 32'h4000 + 32'(4 * i), 32'h0);
        dma_idle();
      end
    join
    chk_gap = 1'b0;
    check("grant_order_done", exp_grant_q.size(), 0);
    repeat (3) @(negedge clk);

    // Memory never acks: timeout, then a late ack must be ignored
    ack_lat = -1;
    cpu_access(1'b1, 1'b0, 32'h200, 32'h0);
    cpu_idle();
    @(negedge clk);
    late_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("late_ack_busy", busy, 1'b0);
    check("late_ack_strb", {mem_re, mem_we}, 2'b00);
    check("late_ack_state", state_dbg, 2'd0);
    ack_lat = 1;
    cpu_access(1'b1, 1'b0, 32'h104, 32'h0);
    cpu_idle();
    repeat (3) @(negedge clk);

    // Reset during ISSUE of a DMA read with a CPU request pending
    ack_lat = -1;
    exp_dma_mem_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0, len: 16'd0});
    dma_read = 1'b1; dma_write = 1'b0; dma_addr = 32'h3000;
    repeat (3) @(negedge clk);
    check("dma_issue_pre_rst", mem_re, 1'b1);
    ack_lat = 1;
    exp_cpu_mem_q.push_back(mk_acc(1'b0, 32'h300, 32'h0));
    exp_cpu_rsp_q.push_back(mk_rsp(1'b0, 32'h300));
    exp_dma_mem_q.push_back(mk_acc(1'b0, 32'h3000, 32'h0));
    exp_dma_rsp_q.push_back(mk_rsp(1'b0, 32'h3000));
    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    ack_lat = -1;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h300;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_issue");
    rst = 1'b0;
    ack_lat = 1;
    wait_cpu_ready();
    cpu_idle();
    wait_dma_ready();
    dma_idle();
    repeat (3) @(negedge clk);

    // Read and write both high: treated as a write
    ack_lat = 0;
    cpu_access(1'b1, 1'b1, 32'h400, 32'hA1B2C3D4);
    cpu_idle();
    repeat (4) @(negedge clk);
    check("rw_store", mem_store.exists(32'h400) ? mem_store[32'h400] : 32'h0, 32'hA1B2C3D4);

    check("cpu_mem_q_empty", exp_cpu_mem_q.size(), 0);
    check("dma_mem_q_empty", exp_dma_mem_q.size(), 0);
    check("cpu_rsp_q_empty", exp_cpu_rsp_q.size(), 0);
    check("dma_rsp_q_empty", exp_dma_rsp_q.size(), 0);
    check("grant_q_empty", exp_grant_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_dma_mem_arbiter.md
# sd_dma_mem_arbiter

Shares the single data-memory port between the CPU load/store path and the SD DMA engine. Each requester holds a level request (read or write, with address and data) until it receives a one-cycle ready pulse. The arbiter serializes requests onto the memory port and returns read data to the winner. The DMA engine's `mem_ready_set` input is driven by this block. CPU has priority, with a bounded-starvation guarantee for DMA and a per-access timeout.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_CPU_RUN`, 4, consecutive CPU grants allowed while DMA is pending; range 1..15
- `TIMEOUT`, 1024, cycles to wait for `mem_ack` before aborting; must be ≥2
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_addr`, `cpu_wdata`  in  ADDR_W/DATA_W  CPU request address and write data
- `cpu_read`, `cpu_write`  in  1  CPU request levels
- `cpu_ready`  out  1  one-cycle completion pulse to CPU
- `cpu_rdata`  out  DATA_W  registered read data, valid with `cpu_ready`
- `cpu_err`  out  1  timeout flag, valid with `cpu_ready`
- `dma_addr`, `dma_wdata`, `dma_read`, `dma_write`  in  -  DMA request (`mem_request_*`)
- `dma_ready`  out  1  pulse; drives DMA `mem_ready_set`
- `dma_rdata`  out  DATA_W  registered read data; drives DMA `mem_data_in`
- `dma_err`  out  1  timeout flag, valid with `dma_ready`
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  memory port address and write data
- `mem_re`, `mem_we`  out  1  memory strobes, held until ack
- `mem_ack`  in  1  memory completion pulse
- `mem_rdata`  in  DATA_W  valid with `mem_ack`
- `grant_dma`  out  1  current or last owner is DMA
- `busy`  out  1  an access is in flight

## Operation
- States:
  - IDLE: arbitrate on the current request levels.
  - ISSUE: memory strobes are asserted.
  - RESP: the ready pulse is driven.
  - IDLE again after RESP.
- Request valid when `read` or `write` is high. If both are high, treat the request as a write.
- Pick rule:
  - Only one side valid: that side wins.
  - Both valid: CPU wins unless `cpu_run == MAX_CPU_RUN`, in which case DMA wins.
- `cpu_run` (4-bit, saturating):
  - +1 on a CPU grant while DMA is valid.
  - Cleared on a DMA grant.
  - Cleared on any IDLE cycle where DMA is not valid.
- On grant: latch owner, addr, wdata and op. Drive `mem_addr`/`mem_wdata`/`mem_re` or `mem_we` from these latches. Strobes are held stable through ISSUE.
- ISSUE → RESP on `mem_ack`. Capture `mem_rdata` into the owner's rdata register (for writes too, so the value is don't-care). Owner's err = 0.
- ISSUE timeout: 11-bit counter reaches `TIMEOUT-1` with no ack → RESP. Owner's err = 1, rdata = 0, strobes drop.
- RESP: pulse the owner's ready for exactly one cycle, then go to IDLE. The non-owner's ready stays low.
- The requester may change addr/op on the cycle after its ready pulse. Because IDLE is entered after RESP, that stale request is never re-served.
- `mem_ack` outside ISSUE is ignored. This includes a late ack after a timeout.
- Reset:
  - Any state → IDLE.
  - All outputs 0: ready, err, rdata, mem_*, `grant_dma`, `busy`.
  - `cpu_run` = 0.
  - An in-flight access is dropped with no ready pulse.

## Timing
- Request high in IDLE at cycle t → strobes high at t+1 (registered).
- Ack at cycle a → ready pulse at a+1 → next arbitration at a+2.
- Zero-wait memory (ack at t+1): 3 cycles per access; back-to-back grants every 3 cycles.
- Timeout: strobes are high for exactly `TIMEOUT` cycles, and ready follows on the next cycle.
- `busy` = 1 in ISSUE and RESP.
- `grant_dma` updates on grant and holds through IDLE.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum `{IDLE, ISSUE, RESP}`.
  - Owner encoding `OWN_CPU = 0`, `OWN_DMA = 1`.
  - Default `TIMEOUT`/`MAX_CPU_RUN` constants.
- One natural combinational sub-module, `mem_arb_pick`, which takes `cpu_valid`, `dma_valid` and `cpu_run` and returns `grant_valid` and owner.
- Timeout counter and FSM stay in the top module.

## Test plan
- CPU read only, `addr=0x100`, memory acks one cycle after the strobe with `0xCAFEBABE` → `cpu_ready` at strobe+2, `cpu_rdata=0xCAFEBABE`, `dma_ready` never pulses.
- DMA write `0x2000/0x12345678`, with the request held across 3 ready pulses and the address advancing by 4 after each → exactly 3 memory writes to `0x2000`, `0x2004`, `0x2008`, no duplicates.
- CPU and DMA both held valid continuously, `MAX_CPU_RUN=4` → grant sequence C,C,C,C,D repeating; DMA waits at most 5 accesses.
- Memory never acks, `TIMEOUT=16` → `mem_re` high for exactly 16 cycles, then `cpu_ready=1`, `cpu_err=1`, `cpu_rdata=0`. A late `mem_ack` two cycles later has no effect.
- `rst` asserted during ISSUE of a DMA read → next cycle all outputs 0, `dma_ready` never pulses. After reset, a pending CPU request is granted first.
- `cpu_read` and `cpu_write` both high → `mem_we=1`, `mem_re=0`.
